// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result bundle for pipelined_adder.
// master drives operands and out_ready; slave is the adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sout;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sout, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sout, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract, CHUNK-bit ripple segment per stage.
// Whole pipeline shifts together and stalls on backpressure.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             adv;
  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  // b is stored pre-inverted for sub, so every stage is a plain add
  always_comb begin
    logic [WIDTH-1:0] as_v;
    logic [WIDTH-1:0] bs_v;
    logic [WIDTH-1:0] ss_v;
    logic             cs_v;
    logic             vs_v;
    logic [CHUNK:0]   t_v;
    adv  = !vld_q[STAGES-1] || bus.out_ready;
    as_v = '0;
    bs_v = '0;
    ss_v = '0;
    cs_v = 1'b0;
    vs_v = 1'b0;
    t_v  = '0;
    for (int k = 0; k < STAGES; k++) begin
      int p;
      p = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        as_v = bus.a;
        bs_v = bus.sub ? ~bus.b : bus.b;
        cs_v = bus.sub ? ~bus.cin : bus.cin;
        ss_v = '0;
        vs_v = bus.in_valid;
      end else begin
        as_v = a_q[p];
        bs_v = b_q[p];
        cs_v = c_q[p];
        ss_v = s_q[p];
        vs_v = vld_q[p];
      end
      t_v = {1'b0, as_v[k*CHUNK +: CHUNK]}
          + {1'b0, bs_v[k*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, cs_v};
      ss_v[k*CHUNK +: CHUNK] = t_v[CHUNK-1:0];
      if (adv) begin
        vld_d[k] = vs_v;
        a_d[k]   = as_v;
        b_d[k]   = bs_v;
        s_d[k]   = ss_v;
        c_d[k]   = t_v[CHUNK];
      end else begin
        vld_d[k] = vld_q[k];
        a_d[k]   = a_q[k];
        b_d[k]   = b_q[k];
        s_d[k]   = s_q[k];
        c_d[k]   = c_q[k];
      end
    end
    // temporaries still hold the last stage's operands here
    if (adv)
      ovf_d = (as_v[WIDTH-1] == bs_v[WIDTH-1])
           && (ss_v[WIDTH-1] != as_v[WIDTH-1]);
    else
      ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sout      = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: vector table, directed
// stall/bubble/reset sequences and a random scoreboard run.
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int C = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    res_t         r;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   got    = 0;
  int   acc    = 0;
  res_t exp_q[$];
  logic hold_pend = 1'b0;
  res_t hold_val;
  logic override = 1'b0;
  res_t ovr_val;
  logic ov_s;
  logic acc_s;

  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic ci, logic sb);
    res_t   m;
    longint r;
    longint sr;
    longint lim;
    lim = longint'(1) << W;
    if (!sb) begin
      r   = longint'(a) + longint'(b) + longint'(ci);
      sr  = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
      m.c = (r >= lim);
    end else begin
      r   = longint'(a) - longint'(b) - longint'(ci);
      sr  = longint'($signed(a)) - longint'($signed(b)) - longint'(ci);
      m.c = (r >= 0);
    end
    m.s = r[W-1:0];
    m.o = (sr > (lim / 2 - 1)) || (sr < -(lim / 2));
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic step();
    res_t cur;
    res_t e;
    @(negedge clk);
    ov_s  = bus.out_valid;
    acc_s = bus.in_valid && bus.in_ready;
    if (rst_n) begin
      cur = {bus.sout, bus.cout, bus.ovf};
      chk("in_ready", 32'(bus.in_ready),
          32'(!bus.out_valid || bus.out_ready));
      if (hold_pend) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(cur), 32'(hold_val));
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %0h want none", cur);
        end else begin
          e = exp_q.pop_front();
          got++;
          if (cur !== e) begin
            errors++;
            $display("FAIL result: got s=%0h c=%0b o=%0b want s=%0h c=%0b o=%0b",
                     cur.s, cur.c, cur.o, e.s, e.c, e.o);
          end
        end
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_val  = cur;
      if (acc_s) begin
        acc++;
        if (override) exp_q.push_back(ovr_val);
        else exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t tab[10];
  logic vin [16];
  logic vout[16];
  int   g0;

  initial begin
    tab[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    tab[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    tab[2] = '{16'h1234, 16'h0FED, 1'b1, 1'b0, '{16'h2222, 1'b0, 1'b0}};
    tab[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
    tab[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
    tab[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
    tab[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
    tab[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, '{16'hFFFF, 1'b0, 1'b0}};
    tab[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
    tab[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, '{16'h8000, 1'b0, 1'b1}};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sout", 32'(bus.sout), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    step();

    // vector table, one beat at a time
    override = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.a = tab[i].a; bus.b = tab[i].b;
      bus.cin = tab[i].ci; bus.sub = tab[i].sb;
      ovr_val = tab[i].r;
      bus.in_valid = 1'b1;
      step();
      drain();
    end
    override = 1'b0;

    // 8 back-to-back beats, backpressure on steps 5..7
    g0 = got;
    acc = 0;
    for (int t = 0; t < 40 && (acc < 8 || exp_q.size() > 0); t++) begin
      bus.in_valid  = (acc < 8);
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.cin       = 1'($urandom);
      bus.sub       = 1'($urandom);
      bus.out_ready = !(t >= 5 && t <= 7);
      step();
      if (t >= 5 && t <= 7) chk("stall_in_ready", 32'(ov_s ? acc_s : 1'b0), 32'd0);
    end
    chk("stall_count", 32'(got - g0), 32'd8);
    drain();

    // alternating valid: output pattern is input delayed by 4
    for (int t = 0; t < 16; t++) begin
      bus.in_valid = (t < 12) && (t % 2 == 0);
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      step();
      vin[t]  = acc_s;
      vout[t] = ov_s;
    end
    for (int t = 0; t < 12; t++)
      chk($sformatf("bubble_%0d", t), 32'(vout[t+4]), 32'(vin[t]));
    drain();

    // async reset with beats in flight and one held at the output
    bus.out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'h4321 + 16'(t);
      bus.b = 16'h1111;
      bus.sub = 1'b0;
      bus.cin = 1'b0;
      step();
    end
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_sout", 32'(bus.sout), 32'd0);
    chk("async_cout", 32'(bus.cout), 32'd0);
    chk("async_ovf", 32'(bus.ovf), 32'd0);
    exp_q.delete();
    hold_pend = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      step();
      chk("no_stale_valid", 32'(ov_s), 32'd0);
    end
    bus.a = 16'h0001; bus.b = 16'h0001;
    bus.cin = 1'b0; bus.sub = 1'b0;
    override = 1'b1;
    ovr_val = '{16'h0002, 1'b0, 1'b0};
    bus.in_valid = 1'b1;
    g0 = got;
    step();
    override = 1'b0;
    drain();
    chk("post_rst_count", 32'(got - g0), 32'd1);

    // randomized traffic against the arithmetic model
    for (int t = 0; t < 400; t++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 4) != 0;
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.cin = 1'($urandom);
      bus.sub = 1'($urandom);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
